// File: rtl/axi_alu_pkg.sv
// ============================================================================
// Module  : axi_alu_pkg
// Brief   : Opcode encoding and width helpers shared by the ALU stream block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    function automatic int calc_iw(input int opw);
        return 2 + 2 * opw;
    endfunction

    function automatic int calc_ow(input int opw);
        return 2 + 2 * opw;
    endfunction

    function automatic int calc_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_alu_fifo.sv
// ============================================================================
// Module  : axi_alu_fifo
// Brief   : Synchronous FIFO with occupancy count; output reads 0 when empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_alu_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/axi_alu_stream.sv
// ============================================================================
// Module  : axi_alu_stream
// Brief   : Streaming ALU (add/sub/and/mul) feeding a result FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_alu_stream
    import axi_alu_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [calc_iw(OPW)-1:0]     rdata,
    input  logic                        rvalid,
    output logic                        rready,
    output logic [calc_ow(OPW)-1:0]     wdata,
    output logic                        wvalid,
    input  logic                        wready,
    output logic [calc_lw(DEPTH)-1:0]   level,
    output logic [15:0]                 op_count
);

    localparam int IW = calc_iw(OPW);
    localparam int OW = calc_ow(OPW);
    localparam int LW = calc_lw(DEPTH);
    localparam int RW = 2 * OPW;

    op_e            op;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW:0]   sum;
    logic [RW-1:0]  a_ext;
    logic [RW-1:0]  b_ext;
    logic [RW-1:0]  res;
    logic           ovf;
    logic [OW-1:0]  result;
    logic           full;
    logic           empty;

    assign op    = op_e'(rdata[IW-1 -: 2]);
    assign a     = rdata[RW-1 -: OPW];
    assign b     = rdata[OPW-1:0];
    assign a_ext = {{OPW{1'b0}}, a};
    assign b_ext = {{OPW{1'b0}}, b};
    assign sum   = {1'b0, a} + {1'b0, b};

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = {{(OPW-1){1'b0}}, sum};
                ovf = sum[OPW];
            end
            OP_SUB: begin
                res = a_ext - b_ext;
                ovf = (a < b);
            end
            OP_AND:  res = a_ext & b_ext;
            OP_MUL:  res = a_ext * b_ext;
            default: res = '0;
        endcase
    end

    assign result = {ovf, (res == '0), res};

    // rready is gated by reset so it stays low while reset is held.
    assign rready = reset && !full;
    assign wvalid = !empty;

    axi_alu_fifo #(
        .WIDTH (OW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rvalid),
        .wr_data (result),
        .rd_en   (wready),
        .rd_data (wdata),
        .count   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count <= '0;
        end else if (wvalid && wready) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

`default_nettype wire
